alu_issue_ctrl: RTL and testbench

- Sequencing stage directly upstream of the 4-bit ALU.
- Accepts 16-bit instructions over a valid/ready handshake and reads operands from a 4-entry x 4-bit register file.
- Drives the ALU inputs (mode, op1, op2, carry-in, enable) from registers, waits a programmable settle time, then captures the ALU result and flags.
- Writes the result back to the register file, holds the carry flag, and feeds it into the next operation.

---
 rtl/alu_issue_ctrl.sv | 139 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer in front of a 4-bit ALU.
// It reads operands from a 4x4 register file and drives the ALU from registers.
// After a programmable settle time it captures the result and writes it back.
module alu_issue_ctrl #(
    parameter int          ALU_WAIT  = 1,
    parameter int          CARRY_IDX = 2,
    parameter logic [3:0]  ALU_EN    = 4'b0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_instr_valid,
    output logic        o_instr_ready,
    input  logic [15:0] i_instr,
    input  logic        i_ld_valid,
    input  logic [1:0]  i_ld_addr,
    input  logic [3:0]  i_ld_data,
    input  logic [1:0]  i_rd_addr,
    output logic [3:0]  o_rd_data,
    output logic [3:0]  o_alu_E,
    output logic [3:0]  o_alu_mode,
    output logic [3:0]  o_alu_op1,
    output logic [3:0]  o_alu_op2,
    output logic        o_alu_cflag,
    input  logic [7:0]  i_alu_result,
    input  logic [3:0]  i_alu_flags,
    output logic        o_done,
    output logic [7:0]  o_wb_data,
    output logic [3:0]  o_flags,
    output logic [7:0]  o_retired
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WB    = 2'd2;

    logic [1:0] state;
    logic [3:0] wait_cnt;
    logic [3:0] regs [4];
    logic       carry;
    logic [1:0] rd_q;
    logic       wide_q;

    logic [3:0] dec_mode;
    logic [1:0] dec_rd;
    logic [1:0] dec_rs1;
    logic [1:0] dec_rs2;
    logic       dec_use_imm;
    logic       dec_wide;
    logic [3:0] dec_imm;
    logic [3:0] src1;
    logic [3:0] src2;

    assign dec_mode    = i_instr[15:12];
    assign dec_rd      = i_instr[11:10];
    assign dec_rs1     = i_instr[9:8];
    assign dec_rs2     = i_instr[7:6];
    assign dec_use_imm = i_instr[5];
    assign dec_wide    = i_instr[4];
    assign dec_imm     = i_instr[3:0];

    // A load landing in the same cycle as an accept is forwarded to the operands.
    always_comb begin
        src1 = regs[dec_rs1];
        src2 = regs[dec_rs2];
        if (i_ld_valid && (i_ld_addr == dec_rs1)) begin
            src1 = i_ld_data;
        end
        if (i_ld_valid && (i_ld_addr == dec_rs2)) begin
            src2 = i_ld_data;
        end
    end

    assign o_instr_ready = (state == IDLE);
    assign o_rd_data     = regs[i_rd_addr];
    assign o_alu_cflag   = carry;
    assign o_alu_E       = ALU_EN;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 4'd0;
            end
            carry      <= 1'b0;
            rd_q       <= 2'd0;
            wide_q     <= 1'b0;
            o_alu_mode <= 4'd0;
            o_alu_op1  <= 4'd0;
            o_alu_op2  <= 4'd0;
            o_done     <= 1'b0;
            o_wb_data  <= 8'd0;
            o_flags    <= 4'd0;
            o_retired  <= 8'd0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_ld_valid) begin
                        regs[i_ld_addr] <= i_ld_data;
                    end
                    if (i_instr_valid) begin
                        o_alu_mode <= dec_mode;
                        o_alu_op1  <= src1;
                        o_alu_op2  <= dec_use_imm ? dec_imm : src2;
                        rd_q       <= dec_rd;
                        wide_q     <= dec_wide;
                        wait_cnt   <= 4'(ALU_WAIT - 1);
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (wait_cnt == 4'd0) begin
                        state <= WB;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                WB: begin
                    // The upper nibble of a wide result goes to the next register, wrapping 3->0.
                    regs[rd_q] <= i_alu_result[3:0];
                    if (wide_q) begin
                        regs[rd_q + 2'd1] <= i_alu_result[7:4];
                    end
                    o_flags   <= i_alu_flags;
                    carry     <= i_alu_flags[CARRY_IDX];
                    o_wb_data <= i_alu_result;
                    o_retired <= o_retired + 8'd1;
                    o_done    <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl; a second instance with ALU_WAIT=4 covers reset during a long issue.
module tb_alu_issue_ctrl;

    logic        i_clk;
    logic        i_rst;
    logic        rst4;
    logic        i_instr_valid;
    logic [15:0] i_instr;
    logic        i_ld_valid;
    logic [1:0]  i_ld_addr;
    logic [3:0]  i_ld_data;
    logic [1:0]  i_rd_addr;
    logic [7:0]  i_alu_result;
    logic [3:0]  i_alu_flags;

    logic        o_instr_ready, o_alu_cflag, o_done;
    logic [3:0]  o_rd_data, o_alu_E, o_alu_mode, o_alu_op1, o_alu_op2, o_flags;
    logic [7:0]  o_wb_data, o_retired;

    logic        d4_ready, d4_cflag, d4_done;
    logic [3:0]  d4_rd_data, d4_E, d4_mode, d4_op1, d4_op2, d4_flags;
    logic [7:0]  d4_wb_data, d4_retired;

    int checks = 0;
    int failures = 0;

    alu_issue_ctrl #(.ALU_WAIT(1), .CARRY_IDX(2), .ALU_EN(4'b0000)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_instr_valid(i_instr_valid), .o_instr_ready(o_instr_ready),
        .i_instr(i_instr), .i_ld_valid(i_ld_valid), .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data),
        .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .o_alu_E(o_alu_E), .o_alu_mode(o_alu_mode),
        .o_alu_op1(o_alu_op1), .o_alu_op2(o_alu_op2), .o_alu_cflag(o_alu_cflag),
        .i_alu_result(i_alu_result), .i_alu_flags(i_alu_flags), .o_done(o_done),
        .o_wb_data(o_wb_data), .o_flags(o_flags), .o_retired(o_retired)
    );

    alu_issue_ctrl #(.ALU_WAIT(4), .CARRY_IDX(2), .ALU_EN(4'b0000)) dut4 (
        .i_clk(i_clk), .i_rst(rst4), .i_instr_valid(i_instr_valid), .o_instr_ready(d4_ready),
        .i_instr(i_instr), .i_ld_valid(i_ld_valid), .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data),
        .i_rd_addr(i_rd_addr), .o_rd_data(d4_rd_data), .o_alu_E(d4_E), .o_alu_mode(d4_mode),
        .o_alu_op1(d4_op1), .o_alu_op2(d4_op2), .o_alu_cflag(d4_cflag),
        .i_alu_result(i_alu_result), .i_alu_flags(i_alu_flags), .o_done(d4_done),
        .o_wb_data(d4_wb_data), .o_flags(d4_flags), .o_retired(d4_retired)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [15:0] mk(input logic [3:0] mode, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2,
                                       input logic use_imm, input logic wide, input logic [3:0] imm);
        return {mode, rd, rs1, rs2, use_imm, wide, imm};
    endfunction

    // All tasks start and end on a falling edge, away from the active edge.
    task automatic load(input logic [1:0] a, input logic [3:0] d);
        i_ld_valid = 1'b1; i_ld_addr = a; i_ld_data = d;
        @(negedge i_clk);
        i_ld_valid = 1'b0;
    endtask

    task automatic issue(input logic [15:0] ins);
        i_instr_valid = 1'b1; i_instr = ins;
        @(negedge i_clk);
        i_instr_valid = 1'b0;
    endtask

    task automatic peek(input logic [1:0] a, output logic [3:0] d, output logic [3:0] d4);
        i_rd_addr = a;
        #1;
        d = o_rd_data;
        d4 = d4_rd_data;
    endtask

    task automatic run_to_done(output int edges);
        edges = 1;
        while (o_done !== 1'b1 && edges < 20) begin
            @(negedge i_clk);
            edges++;
        end
    endtask

    task automatic test_reset;
        logic [3:0] d, d4;
        i_rst = 1'b1; rst4 = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0; rst4 = 1'b0;
        checks++; if (o_instr_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_ready got %b exp 1", o_instr_ready); end
        checks++; if (o_done !== 1'b0) begin failures++; $display("[TB] FAIL rst_done got %b exp 0", o_done); end
        checks++; if (o_retired !== 8'd0) begin failures++; $display("[TB] FAIL rst_retired got %h exp 00", o_retired); end
        checks++; if ({o_alu_mode, o_alu_op1, o_alu_op2} !== 12'h000) begin failures++; $display("[TB] FAIL rst_alu got %h exp 000", {o_alu_mode, o_alu_op1, o_alu_op2}); end
        checks++; if (o_alu_cflag !== 1'b0) begin failures++; $display("[TB] FAIL rst_cflag got %b exp 0", o_alu_cflag); end
        checks++; if (o_flags !== 4'h0 || o_wb_data !== 8'h00) begin failures++; $display("[TB] FAIL rst_flags_wb got %h/%h exp 0/00", o_flags, o_wb_data); end
        checks++; if (o_alu_E !== 4'b0000) begin failures++; $display("[TB] FAIL alu_E got %b exp 0000", o_alu_E); end
        for (int i = 0; i < 4; i++) begin
            peek(2'(i), d, d4);
            checks++; if (d !== 4'h0) begin failures++; $display("[TB] FAIL rst_reg%0d got %h exp 0", i, d); end
        end
        @(negedge i_clk);
    endtask

    task automatic test_basic;
        logic [3:0] d, d4;
        int edges;
        load(2'd0, 4'h3);
        load(2'd1, 4'h5);
        i_alu_result = 8'h08; i_alu_flags = 4'b0100;
        issue(mk(4'h0, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 4'h0));
        checks++; if ({o_alu_mode, o_alu_op1, o_alu_op2} !== 12'h035) begin failures++; $display("[TB] FAIL basic_ops got %h exp 035", {o_alu_mode, o_alu_op1, o_alu_op2}); end
        checks++; if (o_instr_ready !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy got %b exp 0", o_instr_ready); end
        run_to_done(edges);
        checks++; if (edges !== 3) begin failures++; $display("[TB] FAIL basic_latency got %0d exp 3", edges); end
        checks++; if (o_wb_data !== 8'h08 || o_flags !== 4'b0100) begin failures++; $display("[TB] FAIL basic_wb got %h/%b exp 08/0100", o_wb_data, o_flags); end
        checks++; if (o_alu_cflag !== 1'b1) begin failures++; $display("[TB] FAIL basic_cflag got %b exp 1", o_alu_cflag); end
        checks++; if (o_retired !== 8'd1) begin failures++; $display("[TB] FAIL basic_retired got %0d exp 1", o_retired); end
        checks++; if (o_alu_op1 !== 4'h3) begin failures++; $display("[TB] FAIL basic_hold got %h exp 3", o_alu_op1); end
        peek(2'd2, d, d4);
        checks++; if (d !== 4'h8) begin failures++; $display("[TB] FAIL basic_r2 got %h exp 8", d); end
        @(negedge i_clk);
        checks++; if (o_done !== 1'b0) begin failures++; $display("[TB] FAIL basic_done_pulse got %b exp 0", o_done); end
    endtask

    task automatic test_imm;
        logic [3:0] d, d4;
        int edges;
        i_alu_result = 8'h0E; i_alu_flags = 4'b0000;
        issue(mk(4'h1, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0, 4'h0));
        checks++; if ({o_alu_mode, o_alu_op1, o_alu_op2} !== 12'h150) begin failures++; $display("[TB] FAIL imm_ops got %h exp 150", {o_alu_mode, o_alu_op1, o_alu_op2}); end
        checks++; if (o_alu_cflag !== 1'b1) begin failures++; $display("[TB] FAIL imm_cin got %b exp 1", o_alu_cflag); end
        run_to_done(edges);
        checks++; if (edges !== 3) begin failures++; $display("[TB] FAIL imm_latency got %0d exp 3", edges); end
        checks++; if (o_alu_cflag !== 1'b0) begin failures++; $display("[TB] FAIL imm_cflag got %b exp 0", o_alu_cflag); end
        peek(2'd0, d, d4);
        checks++; if (d !== 4'hE) begin failures++; $display("[TB] FAIL imm_r0 got %h exp E", d); end
        @(negedge i_clk);
    endtask

    task automatic test_wide;
        logic [3:0] r0, r1, r2, r3, d4;
        int edges;
        i_alu_result = 8'hA7; i_alu_flags = 4'b1000;
        issue(mk(4'h2, 2'd3, 2'd2, 2'd1, 1'b0, 1'b1, 4'h0));
        checks++; if ({o_alu_op1, o_alu_op2} !== 8'h85) begin failures++; $display("[TB] FAIL wide_ops got %h exp 85", {o_alu_op1, o_alu_op2}); end
        run_to_done(edges);
        checks++; if (o_wb_data !== 8'hA7) begin failures++; $display("[TB] FAIL wide_wb got %h exp A7", o_wb_data); end
        checks++; if (o_alu_cflag !== 1'b0 || o_flags !== 4'b1000) begin failures++; $display("[TB] FAIL wide_flags got %b/%b exp 0/1000", o_alu_cflag, o_flags); end
        peek(2'd3, r3, d4);
        peek(2'd0, r0, d4);
        peek(2'd1, r1, d4);
        peek(2'd2, r2, d4);
        checks++; if ({r0, r1, r2, r3} !== 16'hA587) begin failures++; $display("[TB] FAIL wide_regs got %h exp A587", {r0, r1, r2, r3}); end
        @(negedge i_clk);
    endtask

    task automatic test_forward;
        logic [3:0] d, d4;
        int edges;
        i_alu_result = 8'h0C; i_alu_flags = 4'b0000;
        i_ld_valid = 1'b1; i_ld_addr = 2'd1; i_ld_data = 4'h9;
        issue(mk(4'h3, 2'd2, 2'd1, 2'd3, 1'b0, 1'b0, 4'h0));
        i_ld_valid = 1'b0;
        checks++; if ({o_alu_mode, o_alu_op1, o_alu_op2} !== 12'h397) begin failures++; $display("[TB] FAIL fwd_ops got %h exp 397", {o_alu_mode, o_alu_op1, o_alu_op2}); end
        run_to_done(edges);
        peek(2'd1, d, d4);
        checks++; if (d !== 4'h9) begin failures++; $display("[TB] FAIL fwd_r1 got %h exp 9", d); end
        peek(2'd2, d, d4);
        checks++; if (d !== 4'hC) begin failures++; $display("[TB] FAIL fwd_r2 got %h exp C", d); end
        @(negedge i_clk);
    endtask

    task automatic test_load_in_issue;
        logic [3:0] d, d4;
        i_alu_result = 8'h01; i_alu_flags = 4'b0000;
        issue(mk(4'h4, 2'd3, 2'd0, 2'd0, 1'b1, 1'b0, 4'h5));
        checks++; if (o_alu_op2 !== 4'h5) begin failures++; $display("[TB] FAIL ldi_imm got %h exp 5", o_alu_op2); end
        i_ld_valid = 1'b1; i_ld_addr = 2'd1; i_ld_data = 4'hF;
        @(negedge i_clk);
        @(negedge i_clk);
        i_ld_valid = 1'b0;
        checks++; if (o_done !== 1'b1) begin failures++; $display("[TB] FAIL ldi_done got %b exp 1", o_done); end
        peek(2'd1, d, d4);
        checks++; if (d !== 4'h9) begin failures++; $display("[TB] FAIL ldi_r1 got %h exp 9", d); end
        peek(2'd3, d, d4);
        checks++; if (d !== 4'h1) begin failures++; $display("[TB] FAIL ldi_r3 got %h exp 1", d); end
        @(negedge i_clk);
    endtask

    task automatic test_back_to_back;
        int bad = 0;
        i_alu_result = 8'h00; i_alu_flags = 4'b0000;
        i_instr = mk(4'h0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 4'h1);
        i_instr_valid = 1'b1;
        for (int n = 0; n < 251; n++) begin
            @(negedge i_clk);
            if (o_instr_ready !== 1'b0 || o_done !== 1'b0) bad++;
            @(negedge i_clk);
            if (o_instr_ready !== 1'b0 || o_done !== 1'b0) bad++;
            @(negedge i_clk);
            if (o_instr_ready !== 1'b1 || o_done !== 1'b1) bad++;
            if (n == 249) begin
                checks++; if (o_retired !== 8'd255) begin failures++; $display("[TB] FAIL b2b_255 got %0d exp 255", o_retired); end
            end
        end
        i_instr_valid = 1'b0;
        checks++; if (bad !== 0) begin failures++; $display("[TB] FAIL b2b_ready_pattern got %0d bad cycles exp 0", bad); end
        checks++; if (o_retired !== 8'd0) begin failures++; $display("[TB] FAIL b2b_wrap got %0d exp 0", o_retired); end
        @(negedge i_clk);
        checks++; if (o_instr_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_idle got %b exp 1", o_instr_ready); end
    endtask

    task automatic test_reset_mid;
        logic [3:0] d, d4;
        int seen = 0;
        rst4 = 1'b1;
        @(negedge i_clk);
        rst4 = 1'b0;
        load(2'd0, 4'h6);
        i_alu_result = 8'hFF; i_alu_flags = 4'b1111;
        issue(mk(4'h5, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1, 4'h0));
        checks++; if (d4_ready !== 1'b0 || d4_op1 !== 4'h6) begin failures++; $display("[TB] FAIL mid_issue got %b/%h exp 0/6", d4_ready, d4_op1); end
        @(negedge i_clk);
        rst4 = 1'b1;
        @(negedge i_clk);
        rst4 = 1'b0;
        checks++; if (d4_ready !== 1'b1 || d4_done !== 1'b0) begin failures++; $display("[TB] FAIL mid_ready got %b/%b exp 1/0", d4_ready, d4_done); end
        for (int i = 0; i < 4; i++) begin
            peek(2'(i), d, d4);
            checks++; if (d4 !== 4'h0) begin failures++; $display("[TB] FAIL mid_reg%0d got %h exp 0", i, d4); end
        end
        repeat (8) begin
            @(negedge i_clk);
            if (d4_done === 1'b1) seen++;
        end
        checks++; if (seen !== 0 || d4_retired !== 8'd0 || d4_cflag !== 1'b0) begin failures++; $display("[TB] FAIL mid_no_wb got done=%0d ret=%0d c=%b exp 0/0/0", seen, d4_retired, d4_cflag); end
    endtask

    initial begin
        i_rst = 1'b1; rst4 = 1'b1;
        i_instr_valid = 1'b0; i_instr = 16'h0;
        i_ld_valid = 1'b0; i_ld_addr = 2'd0; i_ld_data = 4'h0;
        i_rd_addr = 2'd0; i_alu_result = 8'h00; i_alu_flags = 4'h0;
        @(negedge i_clk);
        test_reset;
        test_basic;
        test_imm;
        test_wide;
        test_forward;
        test_load_in_issue;
        test_back_to_back;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
